sdram_port_sched: RTL and testbench
===================================

Name: sdram_port_sched

Overview:
- Sequencer sitting between the write/read FIFOs and the SDRAM controller's user ports.
- Decides when to issue write and read burst requests from FIFO fill levels, and arbitrates round-robin when both are pending.
- Generates burst addresses with frame wrap, and manages ping-pong frame banks on address bit 20.
- Never asserts sdram_wr_req and sdram_rd_req together.

Parameters:
WR_BURST, 256, words per write burst (1..511)
RD_BURST, 256, words per read burst (1..1023)
ADDR_MIN, 0, first word address of a frame (bits 19:0)
ADDR_MAX, 307200, exclusive end address of a frame (bits 19:0); ADDR_MAX-ADDR_MIN is a multiple of both bursts
RD_FIFO_DEPTH, 1024, read FIFO capacity in words

Ports:
clk  in  1  100 MHz controller clock
rst_n  in  1  asynchronous active-low reset
sdram_init_done  in  1  controller initialised; no request issued while low
ddr3_pingpang_en  in  1  1 = ping-pong banks, 0 = single bank (bank bit 0)
wr_load  in  1  1-cycle pulse: restart write frame
rd_load  in  1  1-cycle pulse: restart read frame
rd_valid  in  1  read path active (display on)
wr_fifo_used  in  10  words waiting in write FIFO
rd_fifo_used  in  10  words held in read FIFO
sdram_wr_req  out  1  write request to controller
sdram_wr_ack  in  1  high for the duration of the granted write burst
sdram_wr_addr  out  21  {wr_bank, wr_ptr[19:0]}
sdram_wr_burst  out  9  constant WR_BURST
sdram_rd_req  out  1  read request to controller
sdram_rd_ack  in  1  high for the duration of the granted read burst
sdram_rd_addr  out  21  {rd_bank, rd_ptr[19:0]}
sdram_rd_burst  out  10  constant RD_BURST
wr_frame_done  out  1  1-cycle pulse when write pointer wraps
rd_bank  out  1  bank currently being read

Behaviour:
- Reset values:
  - req outputs 0; wr_ptr = rd_ptr = ADDR_MIN.
  - wr_bank 0; rd_bank 0 (rd_bank becomes 1 once ping-pong swaps).
  - wr_frame_done 0; state IDLE; priority pointer = write.
- Service conditions:
  - wr_need = wr_fifo_used >= WR_BURST.
  - rd_need = rd_valid & (rd_fifo_used <= RD_FIFO_DEPTH-RD_BURST).
- FSM:
  - IDLE: stay until sdram_init_done=1, then ARB.
  - ARB: if both needs, grant the side named by the priority pointer. Else grant the single needing side. Else stay. Grant registers req=1 on the next edge (1-cycle latency) and moves to WR_REQ or RD_REQ.
  - WR_REQ/RD_REQ: hold req high until the matching ack=1; drop req in the cycle after ack is seen, then go to WR_ACT/RD_ACT.
  - WR_ACT/RD_ACT: wait for ack falling edge (1->0). On it: ptr += burst, flip the priority pointer to the other side, return to ARB.
- Address arithmetic is 20-bit unsigned. If ptr+burst >= ADDR_MAX, ptr = ADDR_MIN (wrap).
- Write wrap:
  - Pulse wr_frame_done.
  - If ddr3_pingpang_en: wr_bank toggles.
- Read bank:
  - rd_bank is latched only at a read frame start (rd wrap or rd_load).
  - Latched value = ~wr_bank if ddr3_pingpang_en, else 0.
  - A reader therefore never moves to a bank mid-frame, and never reads the bank being written.
- wr_load / rd_load:
  - Received in ARB/IDLE: ptr := ADDR_MIN immediately. A wr_load also toggles wr_bank when ping-pong is enabled; no frame_done pulse.
  - Received during REQ/ACT of the same side: flagged, and applied at burst end in place of the increment. The in-flight address is never changed.
  - Flag cleared at that point; multiple pulses collapse into one.
- Address outputs stay stable from req rise to ack fall.
- sdram_init_done dropping: finish any active burst, then return to IDLE. Pointers are kept.
- Asynchronous reset mid-burst: all outputs return to reset values immediately.
- An ack with no outstanding request is ignored.

Test Plan:
1. Reset, init_done=1, wr_fifo_used=256, rd_valid=0 -> wr_req rises 1 cycle later with addr 0x000000. Hold ack 256 cycles -> next write addr 0x000100.
2. Both needs continuously -> grants alternate W,R,W,R; wr_req and rd_req never high together.
3. Write 1200 bursts, ping-pong on -> after the burst at 0x04AF00: wr_frame_done pulses, wr_addr = 0x100000. Next rd_load gives rd_addr 0x000000 with rd_bank 0.
4. wr_load during WR_ACT at ptr 0x000500 -> addr held until ack falls, then next write addr = {~bank, 0}.
5. rd_fifo_used=800 with RD_BURST 256 -> no rd_req; at 768 -> rd_req.
6. rst_n low mid-RD_ACT -> all outputs at reset values asynchronously; restart begins at 0x000000.

Source files
------------

// File: rtl/sdram_port_sched.sv
// Write/read burst sequencer in front of the SDRAM controller user ports.
// Issues one burst request at a time, alternates sides under contention, and manages ping-pong frame banks.
module sdram_port_sched #(
  parameter int WR_BURST      = 256,
  parameter int RD_BURST      = 256,
  parameter int ADDR_MIN      = 0,
  parameter int ADDR_MAX      = 307200,
  parameter int RD_FIFO_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        ddr3_pingpang_en,
  input  logic        wr_load,
  input  logic        rd_load,
  input  logic        rd_valid,
  input  logic [9:0]  wr_fifo_used,
  input  logic [9:0]  rd_fifo_used,
  output logic        sdram_wr_req,
  input  logic        sdram_wr_ack,
  output logic [20:0] sdram_wr_addr,
  output logic [8:0]  sdram_wr_burst,
  output logic        sdram_rd_req,
  input  logic        sdram_rd_ack,
  output logic [20:0] sdram_rd_addr,
  output logic [9:0]  sdram_rd_burst,
  output logic        wr_frame_done,
  output logic        rd_bank
);

  typedef enum logic [2:0] {IDLE, ARB, WR_REQ, WR_ACT, RD_REQ, RD_ACT} state_t;

  localparam logic [19:0] PTR_MIN = 20'(ADDR_MIN);
  localparam logic [20:0] PTR_END = 21'(ADDR_MAX);
  localparam logic [19:0] WR_STEP = 20'(WR_BURST);
  localparam logic [19:0] RD_STEP = 20'(RD_BURST);

  state_t      state;
  logic [19:0] wr_ptr;
  logic [19:0] rd_ptr;
  logic        wr_bank;
  logic        prio_rd;
  logic        wr_load_pend;
  logic        rd_load_pend;

  logic wr_need;
  logic rd_need;
  logic wr_busy;
  logic rd_busy;
  logic wr_wrap;
  logic rd_wrap;
  logic rd_bank_next;

  assign wr_need      = wr_fifo_used >= 10'(WR_BURST);
  assign rd_need      = rd_valid && ({1'b0, rd_fifo_used} <= 11'(RD_FIFO_DEPTH - RD_BURST));
  assign wr_busy      = (state == WR_REQ) || (state == WR_ACT);
  assign rd_busy      = (state == RD_REQ) || (state == RD_ACT);
  assign wr_wrap      = ({1'b0, wr_ptr} + {1'b0, WR_STEP}) >= PTR_END;
  assign rd_wrap      = ({1'b0, rd_ptr} + {1'b0, RD_STEP}) >= PTR_END;
  // A new read frame always targets the bank the writer is not filling.
  assign rd_bank_next = ddr3_pingpang_en ? ~wr_bank : 1'b0;

  assign sdram_wr_addr  = {wr_bank, wr_ptr};
  assign sdram_rd_addr  = {rd_bank, rd_ptr};
  assign sdram_wr_burst = 9'(WR_BURST);
  assign sdram_rd_burst = 10'(RD_BURST);

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= PTR_MIN;
      rd_ptr        <= PTR_MIN;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      prio_rd       <= 1'b0;
      wr_load_pend  <= 1'b0;
      rd_load_pend  <= 1'b0;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      wr_frame_done <= 1'b0;
    end else begin
      wr_frame_done <= 1'b0;

      // Loads hit the pointer at once unless that side has a burst in flight.
      if (wr_load) begin
        if (wr_busy) begin
          wr_load_pend <= 1'b1;
        end else begin
          wr_ptr <= PTR_MIN;
          if (ddr3_pingpang_en) wr_bank <= ~wr_bank;
        end
      end
      if (rd_load) begin
        if (rd_busy) begin
          rd_load_pend <= 1'b1;
        end else begin
          rd_ptr  <= PTR_MIN;
          rd_bank <= rd_bank_next;
        end
      end

      case (state)
        IDLE: if (sdram_init_done) state <= ARB;
        ARB: begin
          if (!sdram_init_done) begin
            state <= IDLE;
          end else if (wr_need && (!rd_need || !prio_rd)) begin
            sdram_wr_req <= 1'b1;
            state        <= WR_REQ;
          end else if (rd_need) begin
            sdram_rd_req <= 1'b1;
            state        <= RD_REQ;
          end
        end
        WR_REQ: if (sdram_wr_ack) begin
          sdram_wr_req <= 1'b0;
          state        <= WR_ACT;
        end
        WR_ACT: if (!sdram_wr_ack) begin
          // Clearing the flag here overrides a load arriving on this same edge; it is consumed below.
          wr_load_pend <= 1'b0;
          prio_rd      <= 1'b1;
          state        <= ARB;
          if (wr_load_pend || wr_load) begin
            wr_ptr <= PTR_MIN;
            if (ddr3_pingpang_en) wr_bank <= ~wr_bank;
          end else if (wr_wrap) begin
            wr_ptr        <= PTR_MIN;
            wr_frame_done <= 1'b1;
            if (ddr3_pingpang_en) wr_bank <= ~wr_bank;
          end else begin
            wr_ptr <= wr_ptr + WR_STEP;
          end
        end
        RD_REQ: if (sdram_rd_ack) begin
          sdram_rd_req <= 1'b0;
          state        <= RD_ACT;
        end
        RD_ACT: if (!sdram_rd_ack) begin
          rd_load_pend <= 1'b0;
          prio_rd      <= 1'b0;
          state        <= ARB;
          if (rd_load_pend || rd_load || rd_wrap) begin
            rd_ptr  <= PTR_MIN;
            rd_bank <= rd_bank_next;
          end else begin
            rd_ptr <= rd_ptr + RD_STEP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_sched.sv
// Directed bench for sdram_port_sched: a scoreboard queue per side holds the next expected burst address,
// refilled from a small address model each time a burst is acknowledged.
module tb_sdram_port_sched;

  localparam int WR_B = 256;
  localparam int RD_B = 256;
  localparam int AMAX = 307200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdram_init_done = 1'b0;
  logic        ddr3_pingpang_en = 1'b1;
  logic        wr_load = 1'b0;
  logic        rd_load = 1'b0;
  logic        rd_valid = 1'b0;
  logic [9:0]  wr_fifo_used = '0;
  logic [9:0]  rd_fifo_used = '0;
  logic        sdram_wr_req;
  logic        sdram_wr_ack = 1'b0;
  logic [20:0] sdram_wr_addr;
  logic [8:0]  sdram_wr_burst;
  logic        sdram_rd_req;
  logic        sdram_rd_ack = 1'b0;
  logic [20:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst;
  logic        wr_frame_done;
  logic        rd_bank;

  sdram_port_sched #(
    .WR_BURST(WR_B), .RD_BURST(RD_B), .ADDR_MIN(0), .ADDR_MAX(AMAX), .RD_FIFO_DEPTH(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .ddr3_pingpang_en(ddr3_pingpang_en), .wr_load(wr_load), .rd_load(rd_load),
    .rd_valid(rd_valid), .wr_fifo_used(wr_fifo_used), .rd_fifo_used(rd_fifo_used),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack), .sdram_wr_addr(sdram_wr_addr),
    .sdram_wr_burst(sdram_wr_burst), .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
    .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst(sdram_rd_burst),
    .wr_frame_done(wr_frame_done), .rd_bank(rd_bank)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int overlap_cnt = 0;

  logic [20:0] wr_q[$];
  logic [20:0] rd_q[$];
  int   m_wr_ptr, m_rd_ptr;
  logic m_wr_bank, m_rd_bank;
  bit   m_wrapped;

  always @(negedge clk) if (rst_n && sdram_wr_req && sdram_rd_req) overlap_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_ptr = 0; m_rd_ptr = 0; m_wr_bank = 1'b0; m_rd_bank = 1'b0;
    wr_q.delete(); rd_q.delete();
    wr_q.push_back(21'h0); rd_q.push_back(21'h0);
  endtask

  task automatic model_rd_load();
    m_rd_ptr  = 0;
    m_rd_bank = ddr3_pingpang_en ? ~m_wr_bank : 1'b0;
    rd_q.delete();
    rd_q.push_back({m_rd_bank, 20'(m_rd_ptr)});
  endtask

  // Serves one burst: waits for a request, compares side and address, acks for ack_len cycles.
  task automatic serve(input bit exp_side, input int ack_len, input bit load_mid);
    int waited = 0;
    logic [20:0] exp_addr;
    bit wrap = 1'b0;
    while (!(sdram_wr_req || sdram_rd_req) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("req_timeout", 32'(waited < 300), 32'd1);
    if (waited >= 300) return;
    check("grant_side", 32'(sdram_rd_req), 32'(exp_side));
    if (exp_side) exp_addr = (rd_q.size() > 0) ? rd_q.pop_front() : 21'h1fffff;
    else          exp_addr = (wr_q.size() > 0) ? wr_q.pop_front() : 21'h1fffff;
    check(exp_side ? "rd_addr" : "wr_addr", 32'(exp_side ? sdram_rd_addr : sdram_wr_addr), 32'(exp_addr));
    @(negedge clk);
    check("req_held", 32'(exp_side ? sdram_rd_req : sdram_wr_req), 32'd1);
    if (exp_side) sdram_rd_ack = 1'b1; else sdram_wr_ack = 1'b1;
    for (int i = 0; i < ack_len; i++) begin
      @(negedge clk);
      if (i == 0) check("req_drop", 32'(exp_side ? sdram_rd_req : sdram_wr_req), 32'd0);
      if (load_mid && i == 1) begin
        if (exp_side) rd_load = 1'b1; else wr_load = 1'b1;
      end else begin
        wr_load = 1'b0; rd_load = 1'b0;
      end
    end
    wr_load = 1'b0; rd_load = 1'b0;
    check("addr_hold", 32'(exp_side ? sdram_rd_addr : sdram_wr_addr), 32'(exp_addr));
    if (exp_side) sdram_rd_ack = 1'b0; else sdram_wr_ack = 1'b0;
    if (!exp_side) begin
      if (load_mid) begin
        m_wr_ptr = 0;
        if (ddr3_pingpang_en) m_wr_bank = ~m_wr_bank;
      end else if (m_wr_ptr + WR_B >= AMAX) begin
        m_wr_ptr = 0; wrap = 1'b1;
        if (ddr3_pingpang_en) m_wr_bank = ~m_wr_bank;
      end else begin
        m_wr_ptr += WR_B;
      end
      wr_q.push_back({m_wr_bank, 20'(m_wr_ptr)});
    end else begin
      if (load_mid || m_rd_ptr + RD_B >= AMAX) begin
        m_rd_ptr  = 0;
        m_rd_bank = ddr3_pingpang_en ? ~m_wr_bank : 1'b0;
      end else begin
        m_rd_ptr += RD_B;
      end
      rd_q.push_back({m_rd_bank, 20'(m_rd_ptr)});
    end
    m_wrapped = wrap;
    @(negedge clk);
    if (!exp_side) check("frame_done", 32'(wr_frame_done), 32'(wrap));
  endtask

  initial begin
    int rd_seen;
    int waited;
    model_reset();

    // Reset state, and no request while the controller is not initialised.
    #12;
    check("rst_wr_req", 32'(sdram_wr_req), 32'd0);
    check("rst_rd_req", 32'(sdram_rd_req), 32'd0);
    check("rst_wr_addr", 32'(sdram_wr_addr), 32'd0);
    check("rst_rd_addr", 32'(sdram_rd_addr), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
    check("rst_frame_done", 32'(wr_frame_done), 32'd0);
    check("wr_burst_len", 32'(sdram_wr_burst), 32'd256);
    check("rd_burst_len", 32'(sdram_rd_burst), 32'd256);
    @(negedge clk);
    rst_n = 1'b1;
    wr_fifo_used = 10'd256;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("no_req_before_init", 32'(sdram_wr_req), 32'd0);

    // First write at 0x000000 with a full-length ack, then 0x000100.
    sdram_init_done = 1'b1;
    serve(1'b0, 256, 1'b0);
    serve(1'b0, 1, 1'b0);

    // Fresh start: both sides needy, grants alternate starting with write.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd_valid = 1'b1;
    rd_fifo_used = 10'd0;
    for (int i = 0; i < 8; i++) serve(1'(i % 2), 2, 1'b0);

    // Read threshold boundary: 800 held words blocks, 768 allows; stray acks are ignored.
    wr_fifo_used = 10'd0;
    rd_fifo_used = 10'd800;
    rd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      sdram_wr_ack = (i == 5);
      sdram_rd_ack = (i == 8);
      @(negedge clk);
      if (sdram_rd_req || sdram_wr_req) rd_seen++;
    end
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    check("no_req_at_800", 32'(rd_seen), 32'd0);
    rd_fifo_used = 10'd768;
    serve(1'b1, 2, 1'b0);

    // Write to the end of the frame: wrap pulses frame_done and flips to bank 1.
    rd_valid = 1'b0;
    wr_fifo_used = 10'd256;
    m_wrapped = 1'b0;
    for (int n = 0; n < 1300 && !m_wrapped; n++) serve(1'b0, 1, 1'b0);
    wr_fifo_used = 10'd0;
    check("wrap_addr", 32'(sdram_wr_addr), 32'h100000);

    // rd_load after the wrap starts the reader on the bank not being written.
    @(negedge clk);
    rd_load = 1'b1;
    @(negedge clk);
    rd_load = 1'b0;
    model_rd_load();
    check("rd_load_addr", 32'(sdram_rd_addr), 32'h000000);
    check("rd_load_bank0", 32'(rd_bank), 32'd0);

    // wr_load in the middle of the burst at 0x100500: address held, next write at {~bank, 0}.
    wr_fifo_used = 10'd256;
    for (int i = 0; i < 5; i++) serve(1'b0, 1, 1'b0);
    serve(1'b0, 4, 1'b1);
    serve(1'b0, 1, 1'b0);
    wr_fifo_used = 10'd0;
    check("wr_load_bank", 32'(sdram_wr_addr), 32'h000100);
    @(negedge clk);
    rd_load = 1'b1;
    @(negedge clk);
    rd_load = 1'b0;
    model_rd_load();
    check("rd_load_bank1", 32'(rd_bank), 32'd1);
    check("rd_load_addr1", 32'(sdram_rd_addr), 32'h100000);

    // Asynchronous reset in the middle of a read burst.
    rd_valid = 1'b1;
    rd_fifo_used = 10'd0;
    serve(1'b1, 2, 1'b0);
    waited = 0;
    while (!sdram_rd_req && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("rd_req_before_reset", 32'(sdram_rd_req), 32'd1);
    check("rd_addr_before_reset", 32'(sdram_rd_addr), 32'h100100);
    sdram_rd_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rd_req", 32'(sdram_rd_req), 32'd0);
    check("async_wr_req", 32'(sdram_wr_req), 32'd0);
    check("async_rd_addr", 32'(sdram_rd_addr), 32'd0);
    check("async_wr_addr", 32'(sdram_wr_addr), 32'd0);
    check("async_rd_bank", 32'(rd_bank), 32'd0);
    check("async_frame_done", 32'(wr_frame_done), 32'd0);
    sdram_rd_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    serve(1'b1, 2, 1'b0);

    check("req_overlap", 32'(overlap_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
